tc_cu_tiled: RTL and testbench
==============================

# tc_cu_tiled

Parametrised tile-loop sequencer for the sparse tensor core: the next generation of the fixed 16×16×16 control unit. On a `start` pulse it walks the M×N×K GEMM in TILE_N×TILE_K steps (m outer, n-tile middle, k-tile inner), handshakes operand loads with the buffer side, and emits operand pointers, accumulator control and per-row completion. It adds configurable tile and pipeline sizes, a per-row reload mode, compute stall and a done pulse.

## Interface
- M, 16, rows of A/C (iterations of the outer loop)
- N, 16, columns of B/C; must be a multiple of TILE_N
- K, 16, reduction depth; must be a multiple of TILE_K
- TILE_N, 4, columns per issue
- TILE_K, 4, reduction depth per issue
- PIPE_LAT, 2, cycles from the final issue of a row to its out_valid; ≥1
- DW_PTR, 4, pointer width; 2^DW_PTR ≥ max(M,N,K)
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- start  in  1  one-cycle request; ignored unless idle
- mode  in  1  0 = reload operands before every row, 1 = load once; latched on accepted start
- load_ack  in  1  buffer side reports the load is complete
- stall  in  1  freezes issue in COMPUTE
- load_req  out  1  load request
- busy  out  1  high in every state except IDLE
- ptr_m / ptr_n / ptr_k  out  DW_PTR each  current row, column offset, reduction offset
- issue  out  1  tile operation issued this cycle
- acc_clr  out  1  clear accumulator (first k-tile)
- out_valid  out  1  row result ready
- row_out  out  DW_PTR  row index qualified by out_valid
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, COMPUTE, DRAIN.
- IDLE: start=1 → LOAD; ptr_m/n/k cleared to 0; mode latched.
- LOAD: load_req=1. load_ack=1 → COMPUTE. stall is ignored. load_ack outside LOAD is ignored.
- COMPUTE, stall=0: issue=1; acc_clr=1 when ptr_k==0. Pointers present the current tile, then advance at the edge:
  - ptr_k += TILE_K;
  - wrap to 0 at K with ptr_n += TILE_N;
  - ptr_n wraps to 0 at N with ptr_m += 1.
- COMPUTE, stall=1: issue=0 and acc_clr=0; pointers hold.
- Row end is the issue with ptr_n=N−TILE_N and ptr_k=K−TILE_K. It enqueues row ptr_m into the delay line. Next state:
  - DRAIN if ptr_m=M−1;
  - otherwise LOAD if mode=0;
  - otherwise stay in COMPUTE.
- Delay line: PIPE_LAT-stage shift register of {valid, row}. It always advances; stall and state do not hold it. Its output drives out_valid/row_out.
- DRAIN: lasts exactly PIPE_LAT cycles. done=1 in its last cycle, coinciding with out_valid for row M−1. Then IDLE.
- start while busy: ignored. mode changes while busy: no effect.
- Reset (any time, including mid-operation): state IDLE, all outputs 0, pointers 0, delay line flushed.

## Timing
- Reset values: every output is 0.
- load_req rises the cycle after the accepted start (or after a row end in mode 0). It falls the cycle after load_ack is sampled high; COMPUTE begins that same cycle.
- Issue rate: one issue per non-stalled COMPUTE cycle. A row takes (N/TILE_N)·(K/TILE_K) issues; a no-stall row in mode 1 takes that many cycles.
- out_valid for row r is high exactly PIPE_LAT cycles after that row's final issue cycle, for one cycle.
- busy spans from the cycle after start through the done cycle.
- A new start is accepted in the cycle after done.
- Mode-0 row outputs may emerge during the following LOAD; this is legal.

## Test plan
- Defaults, mode=1, load_ack one cycle after load_req, no stall:
  - exactly 1 load_req pulse, 256 issues, 16 out_valid pulses with row_out 0..15;
  - each out_valid lands 2 cycles after the 16th, 32nd, … issue;
  - done is the cycle after issue 256 + 1, then busy=0.
- Mode=0, same stimulus:
  - 16 load_req assertions, ptr_m=0..15 respectively;
  - 256 issues; pointers at 0/0/0 at each row start;
  - acc_clr on 64 issues (ptr_k=0).
- Stall=1 for cycles 5–9 of COMPUTE:
  - issue=0 and pointers frozen for 5 cycles;
  - done delayed by exactly 5 cycles versus the no-stall run;
  - counts unchanged.
- load_ack held 0 for 10 cycles: load_req stays 1, no issue; COMPUTE begins the cycle after ack.
- start pulsed mid-COMPUTE, and load_ack pulsed in IDLE: no state change, no extra issues.
- reset=0 mid-row (ptr_m=7, out_valid pending):
  - all outputs 0 immediately and no out_valid later;
  - a following start runs a full clean 256-issue job.

Source files
------------

// File: rtl/tc_cu_tiled.sv
// ---------------------------------------------------------------------------
// tc_cu_tiled
// Tile-loop sequencer for the sparse tensor core. On an accepted start it walks
// an M x N x K GEMM in TILE_N x TILE_K steps (m outer, n-tile middle, k-tile
// inner), handshakes operand loads, and reports per-row completion through a
// PIPE_LAT-deep delay line that models the compute pipeline.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      one-cycle job request, honoured only when idle
//   i_mode       0 = reload operands before every row, 1 = load once (latched)
//   i_load_ack   buffer side reports the load is complete (used only in LOAD)
//   i_stall      freezes issue while computing
//   o_load_req   load request (high throughout LOAD)
//   o_busy       high in every state except idle
//   o_ptr_m/n/k  current row, column offset, reduction offset
//   o_issue      tile operation issued this cycle
//   o_acc_clr    clear accumulator (first k-tile of a column tile)
//   o_out_valid  row result ready, o_row_out carries the row index
//   o_done       one-cycle completion pulse
// ---------------------------------------------------------------------------
module tc_cu_tiled #(
   parameter int unsigned M        = 16,
   parameter int unsigned N        = 16,
   parameter int unsigned K        = 16,
   parameter int unsigned TILE_N   = 4,
   parameter int unsigned TILE_K   = 4,
   parameter int unsigned PIPE_LAT = 2,
   parameter int unsigned DW_PTR   = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_mode,
   input  logic              i_load_ack,
   input  logic              i_stall,
   output logic              o_load_req,
   output logic              o_busy,
   output logic [DW_PTR-1:0] o_ptr_m,
   output logic [DW_PTR-1:0] o_ptr_n,
   output logic [DW_PTR-1:0] o_ptr_k,
   output logic              o_issue,
   output logic              o_acc_clr,
   output logic              o_out_valid,
   output logic [DW_PTR-1:0] o_row_out,
   output logic              o_done
);

   localparam logic [DW_PTR-1:0] LastM = DW_PTR'(M - 1);
   localparam logic [DW_PTR-1:0] LastN = DW_PTR'(N - TILE_N);
   localparam logic [DW_PTR-1:0] LastK = DW_PTR'(K - TILE_K);
   localparam logic [DW_PTR-1:0] StepN = DW_PTR'(TILE_N);
   localparam logic [DW_PTR-1:0] StepK = DW_PTR'(TILE_K);
   localparam int unsigned       CntW  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [CntW-1:0]   CntLast = CntW'(PIPE_LAT - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StCompute, StDrain} state_e;

   state_e              r_state, w_state_d;
   logic [DW_PTR-1:0]   r_ptr_m, r_ptr_n, r_ptr_k;
   logic [DW_PTR-1:0]   w_ptr_m_d, w_ptr_n_d, w_ptr_k_d;
   logic                r_mode, w_mode_d;
   logic [CntW-1:0]     r_cnt, w_cnt_d;
   logic [PIPE_LAT-1:0] r_dl_vld;
   logic [DW_PTR-1:0]   r_dl_row [PIPE_LAT];

   logic w_issue, w_row_end, w_done;

   assign w_issue   = (r_state == StCompute) && !i_stall;
   // The final issue of a row is the last k-tile of the last column tile.
   assign w_row_end = w_issue && (r_ptr_n == LastN) && (r_ptr_k == LastK);

   always_comb begin
      w_state_d = r_state;
      w_ptr_m_d = r_ptr_m;
      w_ptr_n_d = r_ptr_n;
      w_ptr_k_d = r_ptr_k;
      w_mode_d  = r_mode;
      w_cnt_d   = r_cnt;
      w_done    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_start) begin
               w_state_d = StLoad;
               w_ptr_m_d = '0;
               w_ptr_n_d = '0;
               w_ptr_k_d = '0;
               w_mode_d  = i_mode;
            end
         end
         StLoad: begin
            if (i_load_ack) w_state_d = StCompute;
         end
         StCompute: begin
            if (w_issue) begin
               if (r_ptr_k == LastK) begin
                  w_ptr_k_d = '0;
                  if (r_ptr_n == LastN) begin
                     w_ptr_n_d = '0;
                     w_ptr_m_d = r_ptr_m + 1'b1;
                  end else begin
                     w_ptr_n_d = r_ptr_n + StepN;
                  end
               end else begin
                  w_ptr_k_d = r_ptr_k + StepK;
               end
               if (w_row_end) begin
                  if (r_ptr_m == LastM) begin
                     w_state_d = StDrain;
                     w_cnt_d   = '0;
                     w_ptr_m_d = '0;
                  end else if (!r_mode) begin
                     w_state_d = StLoad;
                  end
               end
            end
         end
         StDrain: begin
            // Final row leaves the delay line in the last drain cycle.
            if (r_cnt == CntLast) begin
               w_done    = 1'b1;
               w_state_d = StIdle;
            end else begin
               w_cnt_d = r_cnt + 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_ptr_m <= '0;
         r_ptr_n <= '0;
         r_ptr_k <= '0;
         r_mode  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_d;
         r_ptr_m <= w_ptr_m_d;
         r_ptr_n <= w_ptr_n_d;
         r_ptr_k <= w_ptr_k_d;
         r_mode  <= w_mode_d;
         r_cnt   <= w_cnt_d;
      end
   end

   // Completion delay line: free-running, never held by stall or state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dl_vld <= '0;
         for (int unsigned i = 0; i < PIPE_LAT; i++) r_dl_row[i] <= '0;
      end else begin
         r_dl_vld[0] <= w_row_end;
         r_dl_row[0] <= w_row_end ? r_ptr_m : '0;
         for (int unsigned i = 1; i < PIPE_LAT; i++) begin
            r_dl_vld[i] <= r_dl_vld[i-1];
            r_dl_row[i] <= r_dl_row[i-1];
         end
      end
   end

   assign o_load_req  = (r_state == StLoad);
   assign o_busy      = (r_state != StIdle);
   assign o_ptr_m     = r_ptr_m;
   assign o_ptr_n     = r_ptr_n;
   assign o_ptr_k     = r_ptr_k;
   assign o_issue     = w_issue;
   assign o_acc_clr   = w_issue && (r_ptr_k == '0);
   assign o_out_valid = r_dl_vld[PIPE_LAT-1];
   assign o_row_out   = r_dl_row[PIPE_LAT-1];
   assign o_done      = w_done;

endmodule

// File: tb/tb_tc_cu_tiled.sv
// ---------------------------------------------------------------------------
// tb_tc_cu_tiled
// Directed bench for tc_cu_tiled at default parameters. A table of job
// scenarios (mode, ack latency, stall window, stray start) is run with a
// per-cycle monitor that checks pointers, acc_clr, out_valid timing/rows and
// busy against a model derived from the issue count; hand-written sequences
// cover reset values, a stray load_ack while idle and reset mid-row.
// ---------------------------------------------------------------------------
module tb_tc_cu_tiled;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, mode = 1'b0, load_ack = 1'b0, stall = 1'b0;
   logic       load_req, busy, issue, acc_clr, out_valid, done;
   logic [3:0] ptr_m, ptr_n, ptr_k, row_out;

   int n_cmp  = 0;
   int n_fail = 0;

   tc_cu_tiled dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .i_mode     (mode),
      .i_load_ack (load_ack),
      .i_stall    (stall),
      .o_load_req (load_req),
      .o_busy     (busy),
      .o_ptr_m    (ptr_m),
      .o_ptr_n    (ptr_n),
      .o_ptr_k    (ptr_k),
      .o_issue    (issue),
      .o_acc_clr  (acc_clr),
      .o_out_valid(out_valid),
      .o_row_out  (row_out),
      .o_done     (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic mode;
      int   ack_d;       // LOAD cycles with ack low before ack
      int   stall_from;  // cycle (start = 0) where stall rises
      int   stall_len;
      int   xstart;      // cycle of a stray start pulse, 0 = none
      int   exp_issue;
      int   exp_loads;
      int   exp_accclr;
      int   exp_first;   // cycle of first issue
      int   exp_done;    // cycle of done pulse
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int all_outs();
      return int'({load_req, busy, ptr_m, ptr_n, ptr_k, issue, acc_clr, out_valid, row_out, done});
   endfunction

   task automatic run_job(input vec_t v, input int abort_cyc, input string tag);
      int cyc = 0, n_issue = 0, n_loads = 0, n_accclr = 0, n_ov = 0, n_done = 0;
      int done_cyc = -1, first_cyc = -1, load_run = 0;
      int ptr_err = 0, acc_err = 0, ov_err = 0, stall_err = 0, ovl_err = 0, busy_err = 0;
      int q_cyc[$];
      int q_row[$];
      logic prev_load = 1'b0, prev_stall = 1'b0;
      logic [3:0] pm = '0, pn = '0, pk = '0;
      bit fin = 0;
      @(posedge clk); #1;
      start = 1'b1;
      mode  = v.mode;
      load_ack = 1'b0;
      stall = 1'b0;
      while (cyc < 3000) begin
         @(negedge clk);
         if (issue) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (int'(ptr_m) != n_issue / 16 || int'(ptr_n) != ((n_issue % 16) / 4) * 4 ||
                int'(ptr_k) != (n_issue % 4) * 4) ptr_err++;
            if (acc_clr != ((n_issue % 4) == 0)) acc_err++;
            n_issue++;
            if (n_issue % 16 == 0) begin
               q_cyc.push_back(cyc + 2);
               q_row.push_back(n_issue / 16 - 1);
            end
         end else if (acc_clr) acc_err++;
         if (acc_clr) n_accclr++;
         if (issue && load_req) ovl_err++;
         if (stall && issue) stall_err++;
         if (stall && prev_stall && {ptr_m, ptr_n, ptr_k} != {pm, pn, pk}) stall_err++;
         if (load_req && !prev_load) begin
            if (int'(ptr_m) != n_loads || ptr_n != 4'd0 || ptr_k != 4'd0) ptr_err++;
            n_loads++;
         end
         if (q_cyc.size() > 0 && q_cyc[0] == cyc) begin
            if (!out_valid || int'(row_out) != q_row[0]) ov_err++;
            void'(q_cyc.pop_front());
            void'(q_row.pop_front());
         end else if (out_valid) ov_err++;
         if (out_valid) n_ov++;
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (cyc == 0 && busy) busy_err++;
         if (cyc >= 1 && done_cyc < 0 && !busy) busy_err++;
         if (done_cyc >= 0 && cyc > done_cyc && busy) busy_err++;
         prev_load = load_req;
         prev_stall = stall;
         {pm, pn, pk} = {ptr_m, ptr_n, ptr_k};
         if (done_cyc >= 0 && cyc == done_cyc + 2) begin
            fin = 1;
            break;
         end
         @(posedge clk); #1;
         cyc++;
         start = (v.xstart != 0 && cyc == v.xstart);
         mode  = ~v.mode;
         if (abort_cyc != 0 && cyc == abort_cyc) begin
            rst_n = 1'b0;
            #1;
            check({tag, " outputs in reset"}, all_outs(), 0);
            start = 1'b0;
            load_ack = 1'b0;
            stall = 1'b0;
            return;
         end
         load_run = load_req ? load_run + 1 : 0;
         load_ack = load_req && (load_run == v.ack_d + 1);
         stall = (cyc >= v.stall_from) && (cyc < v.stall_from + v.stall_len);
      end
      start = 1'b0;
      load_ack = 1'b0;
      stall = 1'b0;
      if (!fin) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s timeout: no done within 3000 cycles", tag);
      end
      check({tag, " issues"}, n_issue, v.exp_issue);
      check({tag, " load_req pulses"}, n_loads, v.exp_loads);
      check({tag, " acc_clr count"}, n_accclr, v.exp_accclr);
      check({tag, " out_valid count"}, n_ov, 16);
      check({tag, " done pulses"}, n_done, 1);
      check({tag, " done cycle"}, done_cyc, v.exp_done);
      check({tag, " first issue cycle"}, first_cyc, v.exp_first);
      check({tag, " pointer errors"}, ptr_err, 0);
      check({tag, " acc_clr errors"}, acc_err, 0);
      check({tag, " out_valid errors"}, ov_err + q_cyc.size(), 0);
      check({tag, " stall errors"}, stall_err, 0);
      check({tag, " issue during load"}, ovl_err, 0);
      check({tag, " busy errors"}, busy_err, 0);
   endtask

   initial begin
      int ov_seen;
      // mode, ack_d, stall_from, stall_len, xstart, issue, loads, accclr, first, done
      vecs[0] = '{1'b1, 1,  0, 0,  0, 256,  1, 64,  3, 260};
      vecs[1] = '{1'b0, 1,  0, 0,  0, 256, 16, 64,  3, 290};
      vecs[2] = '{1'b1, 1,  8, 5,  0, 256,  1, 64,  3, 265};
      vecs[3] = '{1'b0, 1,  8, 5,  0, 256, 16, 64,  3, 295};
      vecs[4] = '{1'b1, 10, 0, 0,  0, 256,  1, 64, 12, 269};
      vecs[5] = '{1'b1, 1,  0, 0, 50, 256,  1, 64,  3, 260};

      repeat (3) @(posedge clk);
      #1;
      check("reset outputs", all_outs(), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Stray load_ack while idle must not start anything.
      load_ack = 1'b1;
      @(posedge clk); #1;
      load_ack = 1'b0;
      @(negedge clk);
      check("idle ack busy/load_req", int'({busy, load_req}), 0);

      for (int i = 0; i < 6; i++) run_job(vecs[i], 0, $sformatf("vec%0d", i));

      // Reset mid-row 7 while row 6 result is still in the delay line.
      run_job(vecs[0], 115, "abort");
      ov_seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) rst_n = 1'b1;
         @(negedge clk);
         if (out_valid || busy) ov_seen++;
         @(posedge clk); #1;
      end
      check("no activity after reset", ov_seen, 0);
      run_job(vecs[0], 0, "post-reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
